// File: rtl/mips_pkg.sv
// Shared MIPS core constants: default GPR geometry and the hardwired-zero register address.
package mips_pkg;

  localparam int unsigned MIPS_ADDR_SIZE = 5;
  localparam int unsigned MIPS_WORD_SIZE = 32;
  localparam int unsigned REG_ZERO       = 0;

endpackage

// File: rtl/regfile_wr_sel.sv
// Write-port selector: for one register address, reports whether any enabled write port
// targets it this cycle and returns the data of the highest-index matching port.
//   addr     in  address being looked up
//   wr_en    in  per-port write enable
//   wr_addr  in  per-port write address, port p at [p*ADDR_SIZE +: ADDR_SIZE]
//   wr_data  in  per-port write data, port p at [p*WORD_SIZE +: WORD_SIZE]
//   hit_c    out some enabled port writes addr (never for the zero register when ZERO_REG=1)
//   data_c   out data from the highest-index matching port, 0 when no hit
module regfile_wr_sel
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = MIPS_ADDR_SIZE,
  parameter int unsigned WORD_SIZE = MIPS_WORD_SIZE,
  parameter int unsigned WR_PORTS  = 2,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic [ADDR_SIZE-1:0]          addr,
  input  logic [WR_PORTS-1:0]           wr_en,
  input  logic [WR_PORTS*ADDR_SIZE-1:0] wr_addr,
  input  logic [WR_PORTS*WORD_SIZE-1:0] wr_data,
  output logic                          hit_c,
  output logic [WORD_SIZE-1:0]          data_c
);

  // Ascending scan so the last (highest-index) match overrides earlier ones.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p] && (wr_addr[p*ADDR_SIZE +: ADDR_SIZE] == addr)) begin
        hit_c  = 1'b1;
        data_c = wr_data[p*WORD_SIZE +: WORD_SIZE];
      end
    end
    if ((ZERO_REG != 0) && (addr == ADDR_SIZE'(REG_ZERO))) begin
      hit_c  = 1'b0;
      data_c = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS GPR file with per-register busy scoreboard and optional write bypass.
//   clk, rst_n  clock, asynchronous active-low reset (clears data and busy bits)
//   rd_addr     RD_PORTS read addresses          rd_data  combinational read data
//   rd_busy     addressed register has an outstanding producer
//   wr_en/wr_addr/wr_data  WR_PORTS write ports, higher index has priority
//   iss_en/iss_addr        reserve a destination register at issue
module regfile_mp
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = MIPS_ADDR_SIZE,
  parameter int unsigned WORD_SIZE = MIPS_WORD_SIZE,
  parameter int unsigned RD_PORTS  = 2,
  parameter int unsigned WR_PORTS  = 2,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RD_PORTS*ADDR_SIZE-1:0] rd_addr,
  output logic [RD_PORTS*WORD_SIZE-1:0] rd_data,
  output logic [RD_PORTS-1:0]           rd_busy,
  input  logic [WR_PORTS-1:0]           wr_en,
  input  logic [WR_PORTS*ADDR_SIZE-1:0] wr_addr,
  input  logic [WR_PORTS*WORD_SIZE-1:0] wr_data,
  input  logic                          iss_en,
  input  logic [ADDR_SIZE-1:0]          iss_addr
);

  localparam int unsigned DEPTH = 2**ADDR_SIZE;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     busy;

  // Per-register storage and scoreboard bit; issue beats a same-cycle write (new producer).
  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    logic                 hit_c;
    logic [WORD_SIZE-1:0] data_c;
    logic                 iss_hit_c;
    logic [WORD_SIZE-1:0] q_data;
    logic                 q_busy;

    regfile_wr_sel #(
      .ADDR_SIZE(ADDR_SIZE),
      .WORD_SIZE(WORD_SIZE),
      .WR_PORTS (WR_PORTS),
      .ZERO_REG (ZERO_REG)
    ) u_sel (
      .addr   (ADDR_SIZE'(r)),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .hit_c  (hit_c),
      .data_c (data_c)
    );

    assign iss_hit_c = iss_en && (iss_addr == ADDR_SIZE'(r)) &&
                       !((ZERO_REG != 0) && (ADDR_SIZE'(r) == ADDR_SIZE'(REG_ZERO)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_data <= '0;
        q_busy <= 1'b0;
      end else begin
        if (hit_c) q_data <= data_c;
        if (iss_hit_c)  q_busy <= 1'b1;
        else if (hit_c) q_busy <= 1'b0;
      end
    end

    assign mem[r]  = q_data;
    assign busy[r] = q_busy;
  end

  // Read ports: forwarded write data (if enabled) wins over stored value and hides busy.
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_SIZE-1:0] addr_c;
    logic                 byp_hit_c;
    logic [WORD_SIZE-1:0] byp_data_c;
    logic                 fwd_c;
    logic                 is_zero_c;

    assign addr_c = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];

    regfile_wr_sel #(
      .ADDR_SIZE(ADDR_SIZE),
      .WORD_SIZE(WORD_SIZE),
      .WR_PORTS (WR_PORTS),
      .ZERO_REG (ZERO_REG)
    ) u_byp (
      .addr   (addr_c),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .hit_c  (byp_hit_c),
      .data_c (byp_data_c)
    );

    assign fwd_c     = (BYPASS != 0) && byp_hit_c;
    assign is_zero_c = (ZERO_REG != 0) && (addr_c == ADDR_SIZE'(REG_ZERO));

    assign rd_data[i*WORD_SIZE +: WORD_SIZE] = fwd_c     ? byp_data_c :
                                               is_zero_c ? '0 : mem[addr_c];
    assign rd_busy[i] = busy[addr_c] && !fwd_c && !is_zero_c;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks of regfile_mp (bypass and no-bypass instances) plus a randomised sweep
// of a 3-read/1-write, 16-entry, 16-bit configuration against a small reference model.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // Default configuration, shared by the bypass and no-bypass instances.
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] nb_rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  nb_rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  // Sweep configuration.
  logic [11:0] s_rd_addr;
  logic [47:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic [0:0]  s_wr_en;
  logic [3:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic        s_iss_en;
  logic [3:0]  s_iss_addr;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [15:0] m_mem [16];
  logic        m_busy [16];

  regfile_mp u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  regfile_mp #(.ADDR_SIZE(4), .WORD_SIZE(16), .RD_PORTS(3), .WR_PORTS(1)) u_sw (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .iss_en(s_iss_en), .iss_addr(s_iss_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
    s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0; s_iss_en = 1'b0;
    s_iss_addr = '0;
    for (int k = 0; k < 16; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end

    // Power-on reset state.
    #2;
    check("por_data", rd_data, 64'h0);
    check("por_busy", {62'h0, rd_busy}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Write r5, reserve r9, then an asynchronous mid-cycle reset pulse.
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    idle();
    rd_addr = {5'd9, 5'd5};
    #1;
    check("r5_written", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    check("r9_reserved", {63'h0, rd_busy[1]}, 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("in_reset_data", rd_data, 64'h0);
    check("in_reset_busy", {62'h0, rd_busy}, 64'h0);
    #1 rst_n = 1'b1;
    #1;
    check("post_reset_r5", {32'h0, rd_data[31:0]}, 64'h0);
    check("post_reset_busy", {62'h0, rd_busy}, 64'h0);

    // 2. Two write ports hit r7 in one cycle: port 1 wins.
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    rd_addr = {5'd0, 5'd7};
    #1;
    check("conflict_byp", {32'h0, rd_data[31:0]}, 64'h22);
    check("conflict_nobyp_old", {32'h0, nb_rd_data[31:0]}, 64'h0);
    @(negedge clk);
    idle();
    #1;
    check("conflict_r7", {32'h0, rd_data[31:0]}, 64'h22);
    check("conflict_r7_nb", {32'h0, nb_rd_data[31:0]}, 64'h22);

    // 3. Register 0 ignores writes and issues.
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    check("r0_byp_data", {32'h0, rd_data[31:0]}, 64'h0);
    check("r0_byp_busy", {63'h0, rd_busy[0]}, 64'h0);
    @(negedge clk);
    idle();
    #1;
    check("r0_data", rd_data, 64'h0);
    check("r0_busy", {62'h0, rd_busy}, 64'h0);

    // 4. Bypass vs stored view when writing r3 while reading it.
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h1234;
    rd_addr = {5'd3, 5'd7};
    #1;
    check("byp_r3", {32'h0, rd_data[63:32]}, 64'h1234);
    check("nobyp_r3_old", {32'h0, nb_rd_data[63:32]}, 64'h0);
    check("byp_other_port", {32'h0, rd_data[31:0]}, 64'h22);
    @(negedge clk);
    idle();
    #1;
    check("nobyp_r3_new", {32'h0, nb_rd_data[63:32]}, 64'h1234);

    // 5. Scoreboard on r9.
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd9;
    rd_addr = {5'd0, 5'd9};
    #1;
    check("sb_iss_same_cycle", {63'h0, rd_busy[0]}, 64'h0);
    @(negedge clk);
    idle();
    #1;
    check("sb_busy", {63'h0, rd_busy[0]}, 64'h1);
    check("sb_busy_nb", {63'h0, nb_rd_busy[0]}, 64'h1);
    @(negedge clk);
    wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h99;
    #1;
    check("sb_fwd_mask", {63'h0, rd_busy[0]}, 64'h0);
    check("sb_fwd_data", {32'h0, rd_data[31:0]}, 64'h99);
    check("sb_nb_still_busy", {63'h0, nb_rd_busy[0]}, 64'h1);
    @(negedge clk);
    idle();
    #1;
    check("sb_cleared", {63'h0, rd_busy[0]}, 64'h0);
    check("sb_cleared_nb", {63'h0, nb_rd_busy[0]}, 64'h0);
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'hAA;
    @(negedge clk);
    idle();
    #1;
    check("sb_iss_wr_busy", {63'h0, nb_rd_busy[0]}, 64'h1);
    check("sb_iss_wr_data", {32'h0, rd_data[31:0]}, 64'hAA);
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    idle();
    #1;
    check("sb_reissue", {63'h0, rd_busy[0]}, 64'h1);
    @(negedge clk);
    wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'hBB;
    @(negedge clk);
    idle();
    #1;
    check("sb_clear_port1", {63'h0, rd_busy[0]}, 64'h0);

    // 6. Random traffic on the 3R/1W, 16x16 instance.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      s_wr_en    = 1'($urandom_range(0, 1));
      s_wr_addr  = 4'($urandom_range(0, 15));
      s_wr_data  = 16'($urandom);
      s_iss_en   = 1'($urandom_range(0, 1));
      s_iss_addr = 4'($urandom_range(0, 15));
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 3) == 0) s_rd_addr[p*4 +: 4] = s_wr_addr;
        else                          s_rd_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
      end
      #1;
      for (int p = 0; p < 3; p++) begin
        logic [3:0]  a;
        logic        fwd;
        logic [15:0] exp_d;
        logic        exp_b;
        a     = s_rd_addr[p*4 +: 4];
        fwd   = s_wr_en[0] && (s_wr_addr == a) && (a != 4'd0);
        exp_d = fwd ? s_wr_data : ((a == 4'd0) ? 16'h0 : m_mem[a]);
        exp_b = (a != 4'd0) && !fwd && m_busy[a];
        check("sweep_data", {48'h0, s_rd_data[p*16 +: 16]}, {48'h0, exp_d});
        check("sweep_busy", {63'h0, s_rd_busy[p]}, {63'h0, exp_b});
      end
      if (s_wr_en[0] && (s_wr_addr != 4'd0)) begin
        m_mem[s_wr_addr]  = s_wr_data;
        m_busy[s_wr_addr] = 1'b0;
      end
      if (s_iss_en && (s_iss_addr != 4'd0)) m_busy[s_iss_addr] = 1'b1;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
